alu_issue_stage: RTL and testbench

- Pipelined ID/EX-side producer for the CPU's 5-bit ALU interface.
- Accepts a fetched MIPS instruction plus register-file read data over a valid/ready handshake.
- Decodes it into alu_op, alu_a and alu_b using the ALU op encoding below, together with destination register and write-enable.
- Registers the result for the execute stage, with stall back-pressure and flush.

---
 rtl/alu_issue_stage_if.sv | 38 +++
 rtl/alu_issue_stage.sv | 193 +++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_stage_if
//  Description : Handshake and payload bundle for the ALU issue stage.
//                Upstream side: in_valid/in_ready with instr, rs_data,
//                rt_data and flush. Downstream side: out_valid/out_ready
//                with alu_op, alu_a, alu_b, wr_reg, wr_en and illegal.
//                The master modport drives the stage inputs. The slave
//                modport is the stage's own view of the bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_issue_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  wr_reg;
  logic        wr_en;
  logic        illegal;

  modport master (
    output in_valid, instr, rs_data, rt_data, flush, out_ready,
    input  in_ready, out_valid, alu_op, alu_a, alu_b, wr_reg, wr_en, illegal
  );

  modport slave (
    input  in_valid, instr, rs_data, rt_data, flush, out_ready,
    output in_ready, out_valid, alu_op, alu_a, alu_b, wr_reg, wr_en, illegal
  );
endinterface
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_stage
//  Description : ID/EX-side producer for the 5-bit ALU interface. It decodes
//                a MIPS instruction and its register read data into alu_op,
//                alu_a, alu_b, wr_reg, wr_en and illegal. It then registers
//                the result behind a valid/ready handshake that supports
//                stall back-pressure and flush.
//  Ports       : clk  - clock
//                rst  - synchronous reset, active-high
//                bus  - alu_issue_stage_if.slave (handshake + payload)
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_stage #(
  parameter bit FLUSH_CLEARS_DATA = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  alu_issue_stage_if.slave   bus
);

  localparam logic [4:0] c_OP_NOP  = 5'd0;
  localparam logic [4:0] c_OP_ADD  = 5'd1;
  localparam logic [4:0] c_OP_SUB  = 5'd2;
  localparam logic [4:0] c_OP_AND  = 5'd3;
  localparam logic [4:0] c_OP_OR   = 5'd4;
  localparam logic [4:0] c_OP_XOR  = 5'd5;
  localparam logic [4:0] c_OP_NOR  = 5'd6;
  localparam logic [4:0] c_OP_ADDU = 5'd7;
  localparam logic [4:0] c_OP_SUBU = 5'd8;
  localparam logic [4:0] c_OP_SLT  = 5'd9;
  localparam logic [4:0] c_OP_SLTU = 5'd10;
  localparam logic [4:0] c_OP_SLL  = 5'd11;
  localparam logic [4:0] c_OP_SRL  = 5'd12;
  localparam logic [4:0] c_OP_SRA  = 5'd13;
  localparam logic [4:0] c_OP_MOV  = 5'd14;
  localparam logic [4:0] c_OP_LUI  = 5'd15;

  // Registered payload
  logic        r_valid;
  logic [4:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [4:0]  r_reg;
  logic        r_wen;
  logic        r_ill;

  // Decode results
  logic [5:0]  w_opcode;
  logic [5:0]  w_funct;
  logic [31:0] w_imm_sx;
  logic [31:0] w_imm_zx;
  logic [31:0] w_shamt;
  logic [31:0] w_rs_sh;
  logic [4:0]  w_op;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [4:0]  w_reg;
  logic        w_en;
  logic        w_ill;
  logic        w_wen;
  logic        w_in_ready;
  logic        w_accept;

  assign w_opcode = bus.instr[31:26];
  assign w_funct  = bus.instr[5:0];
  assign w_imm_sx = {{16{bus.instr[15]}}, bus.instr[15:0]};
  assign w_imm_zx = {16'h0000, bus.instr[15:0]};
  assign w_shamt  = {27'd0, bus.instr[10:6]};
  assign w_rs_sh  = {27'd0, bus.rs_data[4:0]};

  always_comb begin
    w_op  = c_OP_NOP;
    w_a   = 32'd0;
    w_b   = 32'd0;
    w_reg = 5'd0;
    w_en  = 1'b0;
    w_ill = 1'b0;
    // An all-zero word (canonical NOP) keeps every default.
    if (bus.instr != 32'h0) begin
      if (w_opcode == 6'h00) begin
        w_reg = bus.instr[15:11];
        w_en  = 1'b1;
        w_a   = bus.rs_data;
        w_b   = bus.rt_data;
        case (w_funct)
          6'h20: w_op = c_OP_ADD;
          6'h21: w_op = c_OP_ADDU;
          6'h22: w_op = c_OP_SUB;
          6'h23: w_op = c_OP_SUBU;
          6'h24: w_op = c_OP_AND;
          6'h25: w_op = c_OP_OR;
          6'h26: w_op = c_OP_XOR;
          6'h27: w_op = c_OP_NOR;
          6'h2A: w_op = c_OP_SLT;
          6'h2B: w_op = c_OP_SLTU;
          6'h00: begin w_op = c_OP_SLL; w_a = w_shamt; end
          6'h02: begin w_op = c_OP_SRL; w_a = w_shamt; end
          6'h03: begin w_op = c_OP_SRA; w_a = w_shamt; end
          6'h04: begin w_op = c_OP_SLL; w_a = w_rs_sh; end
          6'h06: begin w_op = c_OP_SRL; w_a = w_rs_sh; end
          6'h07: begin w_op = c_OP_SRA; w_a = w_rs_sh; end
          // Conditional moves: the value to move travels on operand B.
          // The condition on rt only gates the write-back.
          6'h0A: begin
            w_op = c_OP_MOV; w_a = 32'd0; w_b = bus.rs_data;
            w_en = (bus.rt_data == 32'd0);
          end
          6'h0B: begin
            w_op = c_OP_MOV; w_a = 32'd0; w_b = bus.rs_data;
            w_en = (bus.rt_data != 32'd0);
          end
          default: begin
            w_a   = 32'd0;
            w_b   = 32'd0;
            w_reg = 5'd0;
            w_en  = 1'b0;
            w_ill = 1'b1;
          end
        endcase
      end else begin
        w_reg = bus.instr[20:16];
        w_en  = 1'b1;
        w_a   = bus.rs_data;
        case (w_opcode)
          6'h08: begin w_op = c_OP_ADD;  w_b = w_imm_sx; end
          6'h09: begin w_op = c_OP_ADDU; w_b = w_imm_sx; end
          6'h0A: begin w_op = c_OP_SLT;  w_b = w_imm_sx; end
          6'h0B: begin w_op = c_OP_SLTU; w_b = w_imm_sx; end
          6'h0C: begin w_op = c_OP_AND;  w_b = w_imm_zx; end
          6'h0D: begin w_op = c_OP_OR;   w_b = w_imm_zx; end
          6'h0E: begin w_op = c_OP_XOR;  w_b = w_imm_zx; end
          6'h0F: begin w_op = c_OP_LUI;  w_a = 32'd0; w_b = w_imm_zx; end
          default: begin
            w_a   = 32'd0;
            w_reg = 5'd0;
            w_en  = 1'b0;
            w_ill = 1'b1;
          end
        endcase
      end
    end
  end

  // $zero is never a write-back target.
  assign w_wen = w_en && (w_reg != 5'd0);

  assign w_in_ready = !bus.flush && (!r_valid || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_op    <= 5'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_reg   <= 5'd0;
      r_wen   <= 1'b0;
      r_ill   <= 1'b0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
      if (FLUSH_CLEARS_DATA) begin
        r_op  <= 5'd0;
        r_a   <= 32'd0;
        r_b   <= 32'd0;
        r_reg <= 5'd0;
        r_wen <= 1'b0;
        r_ill <= 1'b0;
      end
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_op    <= w_op;
      r_a     <= w_a;
      r_b     <= w_b;
      r_reg   <= w_reg;
      r_wen   <= w_wen;
      r_ill   <= w_ill;
    end else if (bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_valid;
  assign bus.alu_op    = r_op;
  assign bus.alu_a     = r_a;
  assign bus.alu_b     = r_b;
  assign bus.wr_reg    = r_reg;
  assign bus.wr_en     = r_wen;
  assign bus.illegal   = r_ill;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_issue_stage
//  Description : Self-checking bench for alu_issue_stage. It runs directed
//                cases with literal expectations, followed by random
//                traffic. Both are compared every cycle against an
//                instruction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rg;
    logic        en;
    logic        ill;
    bit          chk_rg;  // wr_reg is defined for this entry
    bit          chk_ab;  // operands are defined for this entry
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_issue_stage_if bus ();

  alu_issue_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  bit   m_valid  = 1'b0;
  bit   m_known  = 1'b0;
  exp_t m;
  logic last_in_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Instruction-level reference: what the issued entry must carry.
  function automatic exp_t decode(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    exp_t e;
    logic [5:0]  opc = ins[31:26];
    logic [5:0]  fn  = ins[5:0];
    logic [31:0] sx  = 32'($signed(ins[15:0]));
    logic [31:0] zx  = 32'(ins[15:0]);
    e = '{op: 5'd0, a: 32'd0, b: 32'd0, rg: 5'd0, en: 1'b0, ill: 1'b0, chk_rg: 1'b1, chk_ab: 1'b1};
    if (ins == 32'h0) begin
      e.chk_ab = 1'b0;
      return e;
    end
    if (opc == 6'h00) begin
      e.rg = ins[15:11]; e.en = 1'b1; e.a = rs; e.b = rt;
      case (fn)
        6'h20: e.op = 5'd1;   6'h21: e.op = 5'd7;
        6'h22: e.op = 5'd2;   6'h23: e.op = 5'd8;
        6'h24: e.op = 5'd3;   6'h25: e.op = 5'd4;
        6'h26: e.op = 5'd5;   6'h27: e.op = 5'd6;
        6'h2A: e.op = 5'd9;   6'h2B: e.op = 5'd10;
        6'h00: begin e.op = 5'd11; e.a = 32'(ins[10:6]); end
        6'h02: begin e.op = 5'd12; e.a = 32'(ins[10:6]); end
        6'h03: begin e.op = 5'd13; e.a = 32'(ins[10:6]); end
        6'h04: begin e.op = 5'd11; e.a = rs % 32; end
        6'h06: begin e.op = 5'd12; e.a = rs % 32; end
        6'h07: begin e.op = 5'd13; e.a = rs % 32; end
        6'h0A: begin e.op = 5'd14; e.a = 0; e.b = rs; e.en = (rt == 0); end
        6'h0B: begin e.op = 5'd14; e.a = 0; e.b = rs; e.en = (rt != 0); end
        default: begin e.a = 0; e.b = 0; e.en = 0; e.ill = 1; e.chk_rg = 0; end
      endcase
    end else begin
      e.rg = ins[20:16]; e.en = 1'b1; e.a = rs;
      case (opc)
        6'h08: begin e.op = 5'd1;  e.b = sx; end
        6'h09: begin e.op = 5'd7;  e.b = sx; end
        6'h0A: begin e.op = 5'd9;  e.b = sx; end
        6'h0B: begin e.op = 5'd10; e.b = sx; end
        6'h0C: begin e.op = 5'd3;  e.b = zx; end
        6'h0D: begin e.op = 5'd4;  e.b = zx; end
        6'h0E: begin e.op = 5'd5;  e.b = zx; end
        6'h0F: begin e.op = 5'd15; e.a = 0; e.b = zx; end
        default: begin e.a = 0; e.en = 0; e.ill = 1; e.chk_rg = 0; end
      endcase
    end
    if (e.rg == 0) e.en = 1'b0;
    return e;
  endfunction

  // One clock: check in_ready mid-cycle, advance the model, compare outputs.
  task automatic step();
    bit rdy;
    @(negedge clk);
    rdy = !bus.flush && (!m_valid || bus.out_ready);
    last_in_ready = bus.in_ready;
    if (m_known) chk("in_ready", 32'(bus.in_ready), 32'(rdy));
    if (rst) begin
      m_valid = 0;
      m = '{op: 5'd0, a: 32'd0, b: 32'd0, rg: 5'd0, en: 1'b0, ill: 1'b0, chk_rg: 1'b1, chk_ab: 1'b1};
      m_known = 1;
    end else if (bus.flush) begin
      m_valid = 0;
    end else if (bus.in_valid && rdy) begin
      m = decode(bus.instr, bus.rs_data, bus.rt_data);
      m_valid = 1;
    end else if (bus.out_ready) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
    if (m_known) begin
      chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("alu_op", 32'(bus.alu_op), 32'(m.op));
      chk("wr_en", 32'(bus.wr_en), 32'(m.en));
      chk("illegal", 32'(bus.illegal), 32'(m.ill));
      if (m.chk_rg) chk("wr_reg", 32'(bus.wr_reg), 32'(m.rg));
      if (m.chk_ab) begin
        chk("alu_a", bus.alu_a, m.a);
        chk("alu_b", bus.alu_b, m.b);
      end
    end
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    bus.in_valid = 1; bus.instr = ins; bus.rs_data = rs; bus.rt_data = rt;
    bus.out_ready = 1; bus.flush = 0;
    step();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] fl [18] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                            6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h0A, 6'h0B};
    int unsigned k = $urandom_range(0, 9);
    logic [31:0] r = $urandom;
    if (k < 5) begin
      r[31:26] = 6'h00;
      r[5:0]   = fl[$urandom_range(0, 17)];
    end else if (k < 8) begin
      r[31:26] = 6'(8 + $urandom_range(0, 7));
    end else if (k == 8) begin
      r = 32'h0;
    end
    if ($urandom_range(0, 7) == 0) begin
      r[15:11] = 5'd0;
      r[20:16] = 5'd0;
    end
    return r;
  endfunction

  initial begin
    rst = 1; bus.in_valid = 0; bus.instr = 0; bus.rs_data = 0; bus.rt_data = 0;
    bus.flush = 0; bus.out_ready = 1;
    step();
    chk("reset out_valid", 32'(bus.out_valid), 0);
    chk("reset alu_op", 32'(bus.alu_op), 0);
    chk("reset alu_a", bus.alu_a, 0);
    chk("reset alu_b", bus.alu_b, 0);
    chk("reset wr_reg", 32'(bus.wr_reg), 0);
    chk("reset wr_en", 32'(bus.wr_en), 0);
    chk("reset illegal", 32'(bus.illegal), 0);
    rst = 0;

    // Directed decodes with hand-computed results
    issue(32'h00221821, 5, 7);
    chk("addu valid", 32'(bus.out_valid), 1);
    chk("addu op", 32'(bus.alu_op), 7);
    chk("addu a", bus.alu_a, 5);
    chk("addu b", bus.alu_b, 7);
    chk("addu reg", 32'(bus.wr_reg), 3);
    chk("addu en", 32'(bus.wr_en), 1);
    issue(32'h2004FFFF, 0, 0);
    chk("addi op", 32'(bus.alu_op), 1);
    chk("addi b", bus.alu_b, 32'hFFFFFFFF);
    chk("addi reg", 32'(bus.wr_reg), 4);
    issue(32'h34278000, 32'h11, 0);
    chk("ori b", bus.alu_b, 32'h00008000);
    issue(32'h3C051234, 32'hDEAD, 0);
    chk("lui op", 32'(bus.alu_op), 15);
    chk("lui a", bus.alu_a, 0);
    chk("lui b", bus.alu_b, 32'h1234);
    issue(32'h00031103, 0, 32'h80000000);
    chk("sra op", 32'(bus.alu_op), 13);
    chk("sra a", bus.alu_a, 4);
    chk("sra b", bus.alu_b, 32'h80000000);
    issue(32'h00231006, 32'hFFFFFFE3, 1);
    chk("srlv a", bus.alu_a, 3);
    issue(32'h0022300A, 32'h55, 0);
    chk("movz op", 32'(bus.alu_op), 14);
    chk("movz b", bus.alu_b, 32'h55);
    chk("movz en", 32'(bus.wr_en), 1);
    issue(32'h0022300A, 32'h55, 9);
    chk("movz rt9 en", 32'(bus.wr_en), 0);
    issue(32'hFC000000, 1, 2);
    chk("illegal flag", 32'(bus.illegal), 1);
    chk("illegal op", 32'(bus.alu_op), 0);
    chk("illegal en", 32'(bus.wr_en), 0);
    issue(32'h0, 1, 2);
    chk("nop illegal", 32'(bus.illegal), 0);

    // Back-pressure: held entry stays put while in_valid remains high
    issue(32'h00221821, 5, 7);
    bus.out_ready = 0; bus.instr = 32'h34278000;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall in_ready", 32'(last_in_ready), 0);
      chk("stall a", bus.alu_a, 5);
    end
    bus.out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      bus.instr = 32'h00221821 + 32'(i << 11);
      step();
      chk("stream in_ready", 32'(last_in_ready), 1);
      chk("stream valid", 32'(bus.out_valid), 1);
    end

    // Flush while held
    bus.out_ready = 0; bus.instr = 32'h3C051234;
    step();
    bus.flush = 1;
    step();
    chk("flush in_ready", 32'(last_in_ready), 0);
    chk("flush valid", 32'(bus.out_valid), 0);
    bus.flush = 0; bus.in_valid = 0;
    step();
    chk("flush no load", 32'(bus.out_valid), 0);

    // Reset while an entry is held
    issue(32'h00221821, 5, 7);
    bus.out_ready = 0; rst = 1;
    step();
    rst = 0;
    chk("rst held valid", 32'(bus.out_valid), 0);
    chk("rst held op", 32'(bus.alu_op), 0);
    chk("rst held a", bus.alu_a, 0);
    chk("rst held b", bus.alu_b, 0);
    chk("rst held reg", 32'(bus.wr_reg), 0);
    chk("rst held en", 32'(bus.wr_en), 0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.flush     = ($urandom_range(0, 19) == 0);
      rst           = ($urandom_range(0, 99) == 0);
      bus.instr     = rand_instr();
      bus.rs_data   = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      bus.rt_data   = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      step();
    end
    rst = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
